// File: rtl/ae350_reset_sequencer_if.sv
// Board-side signal bundle of the AE350 reset sequencer: async status inputs in,
// registered reset/enable outputs out.
interface ae350_reset_sequencer_if;
    logic       PLL_LOCK;
    logic       DDR3_INIT;
    logic       DDR3_STOP;
    logic       DDR3_RSTN;
    logic       DDR3_CLK_EN;
    logic       POR_RSTN;
    logic       HW_RSTN;
    logic       INIT_FAIL;
    logic [2:0] SEQ_STATE;

    modport master (
        output PLL_LOCK, DDR3_INIT, DDR3_STOP,
        input  DDR3_RSTN, DDR3_CLK_EN, POR_RSTN, HW_RSTN, INIT_FAIL, SEQ_STATE
    );

    modport slave (
        input  PLL_LOCK, DDR3_INIT, DDR3_STOP,
        output DDR3_RSTN, DDR3_CLK_EN, POR_RSTN, HW_RSTN, INIT_FAIL, SEQ_STATE
    );
endinterface

// File: rtl/ae350_reset_sequencer.sv
// Power-up sequencer for the AE350 SoC: PLL lock -> DDR3 reset -> calibration -> SoC resets,
// with calibration retry, sticky failure and full restart on lock loss.
module ae350_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int DDR_RST_HOLD       = 256,
    parameter int INIT_TIMEOUT       = 1048576,
    parameter int MAX_RETRY          = 3,
    parameter int HW_DELAY           = 16
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    ae350_reset_sequencer_if.slave   bus
);
    localparam int MAX_A   = (LOCK_STABLE_CYCLES > DDR_RST_HOLD) ? LOCK_STABLE_CYCLES : DDR_RST_HOLD;
    localparam int MAX_B   = (INIT_TIMEOUT > HW_DELAY) ? INIT_TIMEOUT : HW_DELAY;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    // Wide enough that every terminal count, including HW_DELAY itself, is representable.
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(DDR_RST_HOLD - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(INIT_TIMEOUT - 1);
    localparam logic [CW-1:0] HW_COUNT  = CW'(HW_DELAY);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_DDR_RST   = 3'd2,
        S_WAIT_INIT = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    logic [1:0]    r_rst_sync, r_lk_sync, r_in_sync, r_st_sync;
    state_t        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [RW-1:0] r_retry, w_retry_next;
    logic          r_ddr_rstn, r_clk_en, r_por_rstn, r_hw_rstn, r_init_fail;
    logic          w_rst_rel, w_lk_s, w_in_s, w_st_s;

    assign w_rst_rel = r_rst_sync[1];
    assign w_lk_s    = r_lk_sync[1];
    assign w_in_s    = r_in_sync[1];
    assign w_st_s    = r_st_sync[1];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_rst_sync <= '0;
            r_lk_sync  <= '0;
            r_in_sync  <= '0;
            r_st_sync  <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
            r_lk_sync  <= {r_lk_sync[0], bus.PLL_LOCK};
            r_in_sync  <= {r_in_sync[0], bus.DDR3_INIT};
            r_st_sync  <= {r_st_sync[0], bus.DDR3_STOP};
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_retry_next = r_retry;
        case (r_state)
            S_RESET: begin
                w_retry_next = '0;
                if (w_rst_rel) w_state_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (w_lk_s && (r_cnt == LOCK_LAST)) w_state_next = S_DDR_RST;
            end
            S_DDR_RST: begin
                if (!w_lk_s) begin
                    w_state_next = S_WAIT_LOCK;
                    w_retry_next = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_next = S_WAIT_INIT;
                end
            end
            S_WAIT_INIT: begin
                // Calibration done beats a coincident timeout.
                if (!w_lk_s) begin
                    w_state_next = S_WAIT_LOCK;
                    w_retry_next = '0;
                end else if (w_in_s) begin
                    w_state_next = S_RUN;
                end else if (r_cnt == TO_LAST) begin
                    if (r_retry < RETRY_MAX) begin
                        w_retry_next = r_retry + 1'b1;
                        w_state_next = S_DDR_RST;
                    end else begin
                        w_state_next = S_FAIL;
                    end
                end
            end
            S_RUN: begin
                if (!w_lk_s) begin
                    w_state_next = S_WAIT_LOCK;
                    w_retry_next = '0;
                end
            end
            S_FAIL: begin
                w_state_next = S_FAIL;
            end
            default: begin
                w_state_next = S_RESET;
            end
        endcase

        if (w_state_next != r_state)
            w_cnt_next = '0;
        else if ((r_state == S_WAIT_LOCK) && !w_lk_s)
            w_cnt_next = '0;
        else if (r_cnt != '1)
            w_cnt_next = r_cnt + 1'b1;
        else
            w_cnt_next = r_cnt;
    end

    // Outputs decode the next state so they change on the same edge as the state register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= S_RESET;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_ddr_rstn  <= 1'b0;
            r_clk_en    <= 1'b0;
            r_por_rstn  <= 1'b0;
            r_hw_rstn   <= 1'b0;
            r_init_fail <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_retry     <= w_retry_next;
            r_ddr_rstn  <= (w_state_next == S_WAIT_INIT) || (w_state_next == S_RUN);
            r_clk_en    <= (w_state_next == S_DDR_RST) || (w_state_next == S_WAIT_INIT) ||
                           ((w_state_next == S_RUN) && !w_st_s);
            r_por_rstn  <= (w_state_next == S_RUN);
            r_hw_rstn   <= (w_state_next == S_RUN) && (w_cnt_next >= HW_COUNT);
            r_init_fail <= r_init_fail || (w_state_next == S_FAIL);
        end
    end

    assign bus.DDR3_RSTN   = r_ddr_rstn;
    assign bus.DDR3_CLK_EN = r_clk_en;
    assign bus.POR_RSTN    = r_por_rstn;
    assign bus.HW_RSTN     = r_hw_rstn;
    assign bus.INIT_FAIL   = r_init_fail;
    assign bus.SEQ_STATE   = r_state;
endmodule

// File: tb/tb_ae350_reset_sequencer.sv
// Directed bench for ae350_reset_sequencer with small parameters
// (LOCK=8, HOLD=4, TIMEOUT=32, RETRY=1, HW_DELAY=3).
module tb_ae350_reset_sequencer;
    logic clk;
    logic rstn;
    int   n_total = 0;
    int   n_bad   = 0;

    ae350_reset_sequencer_if bus ();

    ae350_reset_sequencer #(
        .LOCK_STABLE_CYCLES(8),
        .DDR_RST_HOLD      (4),
        .INIT_TIMEOUT      (32),
        .MAX_RETRY         (1),
        .HW_DELAY          (3)
    ) dut (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input string tag, input int want, input int budget, output int n);
        n = 0;
        while ((int'(bus.SEQ_STATE) != want) && (n < budget)) begin
            tick();
            n++;
        end
        chk(tag, int'(bus.SEQ_STATE), want);
    endtask

    task automatic chk_outs(input string tag, input int ddr, input int en, input int por,
                            input int hw, input int fl, input int st);
        chk({tag, ".ddr3_rstn"}, int'(bus.DDR3_RSTN), ddr);
        chk({tag, ".clk_en"},    int'(bus.DDR3_CLK_EN), en);
        chk({tag, ".por_rstn"},  int'(bus.POR_RSTN), por);
        chk({tag, ".hw_rstn"},   int'(bus.HW_RSTN), hw);
        chk({tag, ".init_fail"}, int'(bus.INIT_FAIL), fl);
        chk({tag, ".state"},     int'(bus.SEQ_STATE), st);
    endtask

    initial begin
        int n;
        int low;
        int pulses;
        logic prev;

        rstn          = 1'b0;
        bus.PLL_LOCK  = 1'b1;
        bus.DDR3_INIT = 1'b0;
        bus.DDR3_STOP = 1'b0;
        repeat (3) tick();
        chk_outs("reset", 0, 0, 0, 0, 0, 0);

        // 1: nominal bring-up
        rstn = 1'b1;
        chk("t1.release_state", int'(bus.SEQ_STATE), 0);
        wait_state("t1.to_wait_lock", 1, 10, n);
        wait_state("t1.to_ddr_rst", 2, 20, n);
        chk("t1.lock_cycles", n, 8);
        chk_outs("t1.ddr_rst", 0, 1, 0, 0, 0, 2);
        low = 1;
        while ((bus.DDR3_RSTN == 1'b0) && (low < 50)) begin
            tick();
            if (bus.DDR3_RSTN == 1'b0) begin
                low++;
                chk("t1.clk_en_in_hold", int'(bus.DDR3_CLK_EN), 1);
            end
        end
        chk("t1.ddr_rst_low_cycles", low, 4);
        chk("t1.wait_init_state", int'(bus.SEQ_STATE), 3);
        repeat (10) tick();
        bus.DDR3_INIT = 1'b1;
        wait_state("t1.to_run", 4, 10, n);
        chk("t1.init_sync_latency", n, 3);
        chk_outs("t1.run_entry", 1, 1, 1, 0, 0, 4);
        n = 0;
        while ((bus.HW_RSTN == 1'b0) && (n < 20)) begin
            tick();
            n++;
        end
        chk("t1.hw_delay", n, 3);
        chk("t1.hw_rstn", int'(bus.HW_RSTN), 1);

        // 5: STOP pulse gates the memory clock with 3-cycle latency
        bus.DDR3_STOP = 1'b1;
        repeat (2) tick();
        chk("t5.clk_en_before_gate", int'(bus.DDR3_CLK_EN), 1);
        tick();
        chk("t5.clk_en_gated", int'(bus.DDR3_CLK_EN), 0);
        repeat (2) tick();
        bus.DDR3_STOP = 1'b0;
        chk_outs("t5.gated", 1, 0, 1, 1, 0, 4);
        repeat (2) tick();
        chk("t5.clk_en_still_gated", int'(bus.DDR3_CLK_EN), 0);
        tick();
        chk_outs("t5.ungated", 1, 1, 1, 1, 0, 4);

        // 4: lock loss in RUN, then full re-run
        bus.PLL_LOCK = 1'b0;
        repeat (2) tick();
        chk("t4.still_run", int'(bus.SEQ_STATE), 4);
        tick();
        chk_outs("t4.lock_lost", 0, 0, 0, 0, 0, 1);
        bus.PLL_LOCK = 1'b1;
        wait_state("t4.relock_ddr_rst", 2, 30, n);
        chk("t4.relock_cycles", n, 10);
        wait_state("t4.wait_init", 3, 10, n);
        chk("t4.hold_cycles", n, 4);
        wait_state("t4.run", 4, 10, n);
        chk("t4.init_already_high", n, 1);
        repeat (3) tick();
        chk_outs("t4.rerun", 1, 1, 1, 1, 0, 4);

        // 2: lock glitch restarts the stability count
        rstn          = 1'b0;
        bus.PLL_LOCK  = 1'b0;
        bus.DDR3_INIT = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        wait_state("t2.wait_lock", 1, 10, n);
        repeat (3) tick();
        bus.PLL_LOCK = 1'b1;
        repeat (6) tick();
        bus.PLL_LOCK = 1'b0;
        tick();
        bus.PLL_LOCK = 1'b1;
        wait_state("t2.ddr_rst", 2, 30, n);
        chk("t2.cycles_after_glitch", n, 10);

        // 6: async reset during WAIT_INIT
        wait_state("t6.wait_init", 3, 10, n);
        repeat (5) tick();
        chk_outs("t6.before", 1, 1, 0, 0, 0, 3);
        #3;
        rstn = 1'b0;
        #1;
        chk_outs("t6.async", 0, 0, 0, 0, 0, 0);
        tick();
        rstn = 1'b1;
        chk("t6.restart_state", int'(bus.SEQ_STATE), 0);
        wait_state("t6.wait_lock", 1, 10, n);

        // 3: calibration never completes -> retry once, then FAIL
        wait_state("t3.ddr_rst", 2, 20, n);
        pulses = 1;
        n = 0;
        while ((bus.SEQ_STATE != 3'd5) && (n < 200)) begin
            prev = bus.DDR3_RSTN;
            tick();
            n++;
            if (prev && !bus.DDR3_RSTN && (bus.SEQ_STATE == 3'd2)) pulses++;
        end
        chk("t3.cycles_to_fail", n, 72);
        chk("t3.ddr_rst_pulses", pulses, 2);
        chk_outs("t3.fail", 0, 0, 0, 0, 1, 5);
        bus.PLL_LOCK  = 1'b0;
        bus.DDR3_INIT = 1'b1;
        repeat (6) tick();
        chk_outs("t3.fail_sticky", 0, 0, 0, 0, 1, 5);
        #2;
        rstn = 1'b0;
        #1;
        chk("t3.fail_cleared", int'(bus.INIT_FAIL), 0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
